// File: rtl/spi_master_pkg.sv
// Shared widths, timing constants, opcodes and FSM encodings for the SPI master.
package spi_master_pkg;

  localparam int FRAME_W   = 10;
  localparam int DATA_W    = 8;
  localparam int READ_WAIT = 3;
  localparam int GAP_CYC   = 1;
  localparam int SEL_CYC   = 2;
  localparam int TAIL_CYC  = 2;
  localparam int CNT_W     = $clog2(FRAME_W + 1);

  typedef logic [1:0] opcode_t;
  localparam opcode_t OP_WR_ADDR = 2'b00;
  localparam opcode_t OP_WR_DATA = 2'b01;
  localparam opcode_t OP_RD_ADDR = 2'b10;
  localparam opcode_t OP_RD_DATA = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SEL   = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_TAIL  = 3'd3;
  localparam state_t ST_WAIT  = 3'd4;
  localparam state_t ST_RECV  = 3'd5;
  localparam state_t ST_GAP   = 3'd6;

  // Counter value on the final cycle of each state; the shared counter restarts at 0 on entry.
  function automatic logic [CNT_W-1:0] state_last(input state_t st);
    logic [CNT_W-1:0] last;
    case (st)
      ST_SEL:   last = CNT_W'(SEL_CYC - 1);
      ST_SHIFT: last = CNT_W'(FRAME_W - 1);
      ST_TAIL:  last = CNT_W'(TAIL_CYC - 1);
      ST_WAIT:  last = CNT_W'(READ_WAIT - 1);
      ST_RECV:  last = CNT_W'(DATA_W - 1);
      ST_GAP:   last = CNT_W'(GAP_CYC - 1);
      default:  last = '0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/spi_master_shift.sv
// Datapath for the SPI master: outgoing PISO, incoming SIPO and the shared state counter.
module spi_master_shift
  import spi_master_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_word,
  input  logic               tx_shift,
  input  logic               rx_shift,
  input  logic               miso,
  input  logic               cnt_clr,
  input  logic               cnt_inc,
  output logic               tx_lsb,
  output logic               tx_msb,
  output logic [DATA_W-1:0]  rx_next,
  output logic [CNT_W-1:0]   cnt
);

  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Both registers shift right so the first bit on the wire is bit 0 of the word.
  always_comb begin
    tx_d = tx_q;
    if (load) begin
      tx_d = load_word;
    end else if (tx_shift) begin
      tx_d = {1'b0, tx_q[FRAME_W-1:1]};
    end

    rx_next = {miso, rx_q[DATA_W-1:1]};
    rx_d    = rx_shift ? rx_next : rx_q;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
    end
  end

  assign tx_lsb = tx_q[0];
  assign tx_msb = tx_q[FRAME_W-1];
  assign cnt    = cnt_q;

endmodule

// File: rtl/spi_master.sv
// Host-side SPI initiator: serialises 10-bit command frames and collects read-data bytes.
module spi_master
  import spi_master_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_word,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               err,
  output logic               busy
);

  state_t            state_q, state_d;
  opcode_t           op_q, op_d;
  logic              raddr_seen_q, raddr_seen_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              load, tx_shift, rx_shift, cnt_clr, cnt_inc, last;
  logic              tx_lsb, tx_msb;
  logic [DATA_W-1:0] rx_next;
  logic [CNT_W-1:0]  cnt;
  opcode_t           cmd_op;

  assign cmd_op = cmd_word[FRAME_W-1 -: 2];
  assign last   = (cnt == state_last(state_q));

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    raddr_seen_d = raddr_seen_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    err_d        = 1'b0;
    load         = 1'b0;
    rx_shift     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_RD_DATA && !raddr_seen_q) begin
            err_d = 1'b1;
          end else begin
            op_d    = cmd_op;
            load    = 1'b1;
            state_d = ST_SEL;
          end
        end
      end
      ST_SEL: if (last) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (last) begin
          state_d = (op_q == OP_RD_DATA) ? ST_WAIT : ST_TAIL;
          if (op_q == OP_RD_ADDR) raddr_seen_d = 1'b1;
        end
      end
      ST_TAIL: if (last) state_d = ST_GAP;
      ST_WAIT: if (last) state_d = ST_RECV;
      ST_RECV: begin
        rx_shift = 1'b1;
        if (last) begin
          rd_data_d    = rx_next;
          rd_valid_d   = 1'b1;
          raddr_seen_d = 1'b0;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: if (last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    tx_shift = (state_d == ST_SHIFT);
    cnt_clr  = (state_d != state_q);
    cnt_inc  = (state_q != ST_IDLE) && !cnt_clr;

    ss_n_d  = (state_d == ST_IDLE) || (state_d == ST_GAP);
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);

    case (state_d)
      ST_SEL:   mosi_d = (state_q == ST_IDLE) ? cmd_word[FRAME_W-1] : tx_msb;
      ST_SHIFT: mosi_d = tx_lsb;
      default:  mosi_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_WR_ADDR;
      raddr_seen_q <= 1'b0;
      ss_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      raddr_seen_q <= raddr_seen_d;
      ss_n_q       <= ss_n_d;
      mosi_q       <= mosi_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  spi_master_shift u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_word (cmd_word),
    .tx_shift  (tx_shift),
    .rx_shift  (rx_shift),
    .miso      (MISO),
    .cnt_clr   (cnt_clr),
    .cnt_inc   (cnt_inc),
    .tx_lsb    (tx_lsb),
    .tx_msb    (tx_msb),
    .rx_next   (rx_next),
    .cnt       (cnt)
  );

  assign cmd_ready = ready_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench: spi_master driving a behavioural SPI slave with a 256-byte RAM.
module tb_spi_master;
  import spi_master_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic [FRAME_W-1:0] cmd_word = '0;
  logic               miso = 1'b0;
  logic               cmd_ready, ss_n, mosi, rd_valid, err, busy;
  logic [DATA_W-1:0]  rd_data;

  always #5 clk = ~clk;

  spi_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_word  (cmd_word),
    .SS_n      (ss_n),
    .MOSI      (mosi),
    .MISO      (miso),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .err       (err),
    .busy      (busy)
  );

  typedef struct {
    logic [FRAME_W-1:0] word;
    int                 len;
  } frame_t;

  frame_t            frame_q[$];
  logic [DATA_W-1:0] rd_q[$];
  int                tests_run = 0;
  int                tests_failed = 0;

  logic [7:0] ref_mem   [256];
  logic [7:0] slave_mem [256];
  logic [7:0] ref_waddr = '0;
  logic [7:0] ref_raddr = '0;
  bit         ref_seen = 1'b0;

  logic [7:0]         slv_waddr = '0;
  logic [7:0]         slv_raddr = '0;
  logic [7:0]         slv_byte = '0;
  logic [FRAME_W-1:0] rx_frame = '0;
  frame_t             cur;
  int                 idx = 0;
  int                 gap = 0;
  int                 zero_viol = 0;
  bit                 have_prev = 1'b0;
  bit                 expect_abort = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: predicts the frame, any read byte, and whether the command is rejected.
  task automatic modelCommand(input logic [FRAME_W-1:0] w, output bit is_err);
    frame_t f;
    is_err = (w[9:8] == OP_RD_DATA) && !ref_seen;
    if (!is_err) begin
      f.word = w;
      f.len  = (w[9:8] == OP_RD_DATA) ? 23 : 14;
      frame_q.push_back(f);
      case (w[9:8])
        OP_WR_ADDR: ref_waddr = w[7:0];
        OP_WR_DATA: ref_mem[ref_waddr] = w[7:0];
        OP_RD_ADDR: begin ref_raddr = w[7:0]; ref_seen = 1'b1; end
        default:    begin rd_q.push_back(ref_mem[ref_raddr]); ref_seen = 1'b0; end
      endcase
    end
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && frame_q.size() == 0) begin ok = 1'b1; break; end
    end
    checkOutput("idle_wait", ok, 1);
  endtask

  // Issues one command and checks the handshake response in the first cycle after accept.
  task automatic applyStimulus(input logic [FRAME_W-1:0] w);
    bit ok, is_err;
    waitReady(ok);
    checkOutput("ready_wait", ok, 1);
    if (!ok) return;
    modelCommand(w, is_err);
    cmd_word  = w;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_c1", err, is_err);
    checkOutput("ss_n_c1", ss_n, is_err);
    checkOutput("busy_c1", busy, !is_err);
    checkOutput("ready_c1", cmd_ready, is_err);
    if (is_err) begin
      @(negedge clk);
      checkOutput("err_c2", err, 0);
      checkOutput("ss_n_c2", ss_n, 1);
      checkOutput("rd_valid_c2", rd_valid, 0);
    end
  endtask

  // Keeps cmd_valid high with a new word during a frame; it must wait for IDLE.
  task automatic applyHeld(input logic [FRAME_W-1:0] a, input logic [FRAME_W-1:0] b);
    bit ok, e;
    waitReady(ok);
    checkOutput("ready_wait", ok, 1);
    if (!ok) return;
    modelCommand(a, e);
    cmd_word  = a;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_word = b;
    modelCommand(b, e);
    @(negedge clk);
    checkOutput("ready_held", cmd_ready, 0);
    waitReady(ok);
    checkOutput("held_accept", ok, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Behavioural slave: counts SS_n-low cycles, decodes frames, drives MISO mid-cycle.
  always @(negedge clk) begin
    if (ss_n && mosi) zero_viol++;
    if (!ss_n) begin
      idx++;
      if (idx == 1) begin
        if (have_prev) checkOutput("gap", gap >= 1, 1);
        checkOutput("frame_avail", frame_q.size() != 0, 1);
        if (frame_q.size() != 0) cur = frame_q.pop_front();
        rx_frame = '0;
      end
      if (idx <= 2) begin
        checkOutput("cmd_bit", mosi, cur.word[FRAME_W-1]);
      end else if (idx <= 12) begin
        rx_frame[idx-3] = mosi;
        if (idx == 12) begin
          checkOutput("frame", rx_frame, cur.word);
          case (rx_frame[9:8])
            OP_WR_ADDR: slv_waddr = rx_frame[7:0];
            OP_WR_DATA: slave_mem[slv_waddr] = rx_frame[7:0];
            OP_RD_ADDR: slv_raddr = rx_frame[7:0];
            default:    slv_byte = slave_mem[slv_raddr];
          endcase
        end
      end else if (mosi) begin
        zero_viol++;
      end
      if (idx >= 16 && idx <= 23) miso = slv_byte[idx-16];
      else miso = ~slv_byte[0];
    end else begin
      if (idx > 0) begin
        if (idx < 12) begin
          checkOutput("abort_expected", expect_abort, 1);
          expect_abort = 1'b0;
          have_prev = 1'b0;
        end else begin
          checkOutput("frame_len", idx, cur.len);
          have_prev = 1'b1;
        end
        idx = 0;
        gap = 0;
      end
      gap++;
      miso = ~slv_byte[DATA_W-1];
    end
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      checkOutput("rd_avail", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) checkOutput("rd_data", rd_data, rd_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 8'(i) ^ 8'h5A;
      slave_mem[i] = 8'(i) ^ 8'h5A;
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_ss_n", ss_n, 1);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;

    $display("[TB] read-data with no prior read-address");
    applyStimulus(10'h300);

    $display("[TB] write address 5, data A5");
    applyStimulus(10'h005);
    applyStimulus(10'h1A5);
    waitIdle();
    checkOutput("ram5", slave_mem[5], 8'hA5);

    $display("[TB] read back address 5");
    applyStimulus(10'h205);
    applyStimulus(10'h300);
    applyStimulus(10'h300);
    waitIdle();

    $display("[TB] cmd_valid held across a frame");
    applyHeld(10'h033, 10'h15A);
    waitIdle();

    $display("[TB] reset during shift");
    applyStimulus(10'h2AA);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    expect_abort = 1'b1;
    ref_seen = 1'b0;
    #1;
    checkOutput("abort_ss_n", ss_n, 1);
    checkOutput("abort_mosi", mosi, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ready", cmd_ready, 1);
    checkOutput("abort_rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(10'h300);
    applyStimulus(10'h00F);
    waitIdle();

    $display("[TB] write between read-address and read-data");
    applyStimulus(10'h2FF);
    applyStimulus(10'h13C);
    applyStimulus(10'h300);
    applyStimulus(10'h20F);
    applyStimulus(10'h300);
    waitIdle();

    $display("[TB] random write/read pairs");
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      applyStimulus({OP_WR_ADDR, a});
      applyStimulus({OP_WR_DATA, d});
      applyStimulus({OP_RD_ADDR, a});
      applyStimulus({OP_RD_DATA, 8'h00});
    end
    waitIdle();
    repeat (3) @(negedge clk);

    checkOutput("frames_left", frame_q.size(), 0);
    checkOutput("reads_left", rd_q.size(), 0);
    checkOutput("mosi_zero", zero_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
